// File: rtl/gpio_pattern_gen_if.sv
// Button inputs and pattern/status outputs of the GPIO pattern generator.
// master drives the buttons and observes the pattern; slave is the generator.
interface gpio_pattern_gen_if #(
  parameter int WIDTH = 26
);
  localparam int POS_W = $clog2(WIDTH);

  logic             btn_mode;
  logic             btn_step;
  logic [WIDTH-1:0] gpio_out;
  logic [POS_W-1:0] pos;
  logic [1:0]       mode;
  logic             tick;

  modport master (
    output btn_mode, btn_step,
    input  gpio_out, pos, mode, tick
  );

  modport slave (
    input  btn_mode, btn_step,
    output gpio_out, pos, mode, tick
  );
endinterface

// File: rtl/gpio_pattern_gen.sv
// Purpose: debounced two-button GPIO test-pattern generator (square / walking one / step / off).
// Latency: press pulse DEBOUNCE+2 cycles after a clean button edge; outputs update one cycle after a tick or press.
// Backpressure: none; buttons are free-running asynchronous inputs and outputs are always valid.
module gpio_pattern_gen #(
  parameter int WIDTH    = 26,
  parameter int TICK_DIV = 12500000,
  parameter int DEBOUNCE = 250000
) (
  input  logic                clk_25mhz,
  input  logic                rst_n,
  gpio_pattern_gen_if.slave   bus
);
  localparam int POS_W = $clog2(WIDTH);
  localparam int TD_W  = $clog2(TICK_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE);

  typedef enum logic [1:0] {
    SQUARE    = 2'd0,
    WALK_AUTO = 2'd1,
    WALK_STEP = 2'd2,
    OFF       = 2'd3
  } mode_e;

  // index 0 = mode button, index 1 = step button
  logic [1:0]      sync1, sync2, lvl, btn_press;
  logic [DB_W-1:0] db_cnt [2];

  mode_e            mode_q, mode_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_inc;
  logic             phase_q, phase_d;
  logic [TD_W-1:0]  presc_q, presc_d;
  logic [WIDTH-1:0] gpio_q, gpio_d;
  logic             tick;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      lvl       <= '0;
      btn_press <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {bus.btn_step, bus.btn_mode};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        btn_press[i] <= 1'b0;
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          // level accepted on the DEBOUNCE-th differing cycle; only rising edges pulse
          db_cnt[i]    <= '0;
          lvl[i]       <= sync2[i];
          btn_press[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tick    = (presc_q == TD_W'(TICK_DIV - 1));
  assign pos_inc = (pos_q == POS_W'(WIDTH - 1)) ? '0 : pos_q + 1'b1;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= SQUARE;
      pos_q   <= '0;
      phase_q <= 1'b0;
      presc_q <= '0;
      gpio_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      presc_q <= presc_d;
      gpio_q  <= gpio_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    gpio_d  = '0;

    // a mode press overrides any tick or step in the same cycle
    if (btn_press[0]) begin
      case (mode_q)
        SQUARE:    mode_d = WALK_AUTO;
        WALK_AUTO: mode_d = WALK_STEP;
        WALK_STEP: mode_d = OFF;
        OFF:       mode_d = SQUARE;
        default:   mode_d = SQUARE;
      endcase
      pos_d   = '0;
      phase_d = 1'b0;
      presc_d = '0;
    end else begin
      case (mode_q)
        SQUARE:    if (tick) phase_d = ~phase_q;
        WALK_AUTO: if (tick) pos_d = pos_inc;
        WALK_STEP: if (btn_press[1]) pos_d = pos_inc;
        OFF:       pos_d = '0;
        default:   pos_d = '0;
      endcase
    end

    case (mode_d)
      SQUARE:               gpio_d = {WIDTH{phase_d}};
      WALK_AUTO, WALK_STEP: gpio_d = {{(WIDTH-1){1'b0}}, 1'b1} << pos_d;
      default:              gpio_d = '0;
    endcase
  end

  assign bus.gpio_out = gpio_q;
  assign bus.pos      = pos_q;
  assign bus.mode     = mode_q;
  assign bus.tick     = tick;
endmodule

// File: doc/gpio_pattern_gen.md
GPIO_PATTERN_GEN -- requirements
Module: gpio_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 26, is the number of GPIO outputs driven (2..32).
REQ-002 Parameter TICK_DIV, default 12500000, is the number of clk_25mhz cycles per pattern tick (0.5 s); minimum 2.
REQ-003 Parameter DEBOUNCE, default 250000, is the number of consecutive stable cycles needed to accept a button level (10 ms); minimum 2.
REQ-004 Port clk_25mhz, input, 1 bit: the single clock; all logic is on this clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port btn_mode, input, 1 bit: raw asynchronous mode button, active-high.
REQ-007 Port btn_step, input, 1 bit: raw asynchronous step button, active-high.
REQ-008 Port gpio_out, output, WIDTH bits: registered test pattern for the header pins.
REQ-009 Port pos, output, POS_W = ceil(log2(WIDTH)) bits: current walking index.
REQ-010 Port mode, output, 2 bits: current mode encoding, for the LEDs.
REQ-011 Port tick, output, 1 bit: single-cycle prescaler pulse.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE consecutive cycles; the counter clears on any cycle where they are equal.
REQ-014 A press SHALL be a one-cycle pulse on each 0->1 transition of the debounced level; releases generate nothing.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick is high exactly in the cycle where the count equals TICK_DIV-1.
REQ-016 Mode FSM: SQUARE(0) -> WALK_AUTO(1) -> WALK_STEP(2) -> OFF(3) -> SQUARE(0), advancing one state per mode press.
REQ-017 On a mode press the block SHALL clear pos, the prescaler count and the square phase in the same edge that updates mode.
REQ-018 SQUARE: phase toggles on each tick; gpio_out = all bits equal to phase.
REQ-019 WALK_AUTO: gpio_out = one-hot with bit pos set; pos increments on each tick and wraps from WIDTH-1 to 0.
REQ-020 WALK_STEP: pos increments on each step press only, with the same wrap; ticks do not change pos.
REQ-021 OFF: gpio_out = all zeros; pos holds 0.
REQ-022 Step presses outside WALK_STEP SHALL be ignored.
REQ-023 A mode press coincident with a tick or step press SHALL win; no pos or phase advance occurs in that cycle.
REQ-024 gpio_out, pos and mode SHALL be registered and reflect an event one cycle after the tick or press pulse; on mode entry, gpio_out shows the new mode's pattern at pos=0 (WALK modes: bit 0 set; others: zero).

Reset
REQ-025 While rst_n=0, the block SHALL force mode=SQUARE, pos=0, phase=0, gpio_out=0, tick=0, prescaler=0, debounce counters=0, synchronizers and debounced levels=0, without waiting for a clock edge.
REQ-026 A button held through reset release SHALL register as a press DEBOUNCE+2 cycles after release, with behavior otherwise identical to a normal press.
REQ-027 Reset asserted in any state, including mid-debounce or mid-walk, SHALL abort the operation with no residual pulse after release.

Verification (WIDTH=26, TICK_DIV=4, DEBOUNCE=3)
REQ-028 Release reset, buttons low -> tick every 4th cycle; gpio_out alternates 26'h3FFFFFF / 26'h0 on each tick; mode=0.
REQ-029 One clean mode press -> mode=1, gpio_out=26'h1; after 5 ticks gpio_out=26'h20, pos=5; after 26 ticks gpio_out returns to 26'h1.
REQ-030 btn_mode high for 2 cycles only -> no press; mode stays 0.
REQ-031 In mode 2, three step presses with ticks running -> pos=3, gpio_out=26'h8; ticks alone leave pos unchanged; in mode 1, step presses have no effect.
REQ-032 Mode press aligned with a tick in mode 1 at pos=7 -> mode=2, pos=0, gpio_out=26'h1; a fourth press from mode 3 returns mode to 0.
REQ-033 rst_n pulled low mid-walk at pos=10 -> gpio_out=0, mode=0, pos=0 immediately, before the next clock edge.
